// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with an optional bimodal 2-bit direction
// predictor. The fetch stage looks up a PC combinationally. The execute stage
// writes back resolved control-flow outcomes through a single write port.
//
// Parameters
//   PC_W     PC width in bits
//   ENTRIES  table depth (power of two, 2..256); IDX_W = log2(ENTRIES)
//   MODE     0 = static not-taken (pred_taken tied low), 1 = bimodal 2-bit
//
// Ports
//   cpu_clk       clock
//   cpu_rst       asynchronous active-high reset
//   if_valid      fetch presents a valid PC this cycle (counted in stat_lookups)
//   if_pc         fetch PC to look up
//   pred_hit      valid entry whose tag matches if_pc
//   pred_taken    predict taken (hit & counter MSB in MODE=1, else 0)
//   pred_target   predicted target, 0 on miss
//   upd_valid     a control-flow instruction resolved this cycle
//   upd_pc        PC of the resolved instruction
//   upd_taken     actual outcome
//   upd_is_jump   unconditional jump (jal/jalr); forces the counter to 11
//   upd_target    actual target
//   upd_mispred   the pipeline flushed for this instruction
//   stat_lookups  saturating count of if_valid cycles
//   stat_mispred  saturating count of upd_valid & upd_mispred cycles
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int MODE    = 1
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispred,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // 2-bit saturating counter encodings
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_STRONG  = 2'b11;

  // Table storage
  logic            valid_q [ENTRIES];
  tag_t            tag_q   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];
  logic [PC_W-1:0] tgt_q   [ENTRIES];

  // PC[1:0] never participates: instructions are word aligned.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational read of the current (pre-update) contents, so
  // a same-cycle update to the same index becomes visible only next cycle.
  // ---------------------------------------------------------------------------
  idx_t lk_idx;
  tag_t lk_tag;
  logic lk_hit;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[PC_W-1:IDX_W+2];
  // Gating with cpu_rst keeps the outputs low for the whole reset window.
  assign lk_hit = !cpu_rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_hit    = lk_hit;
  assign pred_target = lk_hit ? tgt_q[lk_idx] : '0;

  generate
    if (MODE == 1) begin : g_bimodal
      assign pred_taken = lk_hit & ctr_q[lk_idx][1];
    end else begin : g_static
      assign pred_taken = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Update: next counter value for a hitting entry
  // ---------------------------------------------------------------------------
  idx_t       up_idx;
  tag_t       up_tag;
  logic       up_hit;
  logic [1:0] up_ctr_cur;
  logic [1:0] up_ctr_nxt;

  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[PC_W-1:IDX_W+2];
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_cur = ctr_q[up_idx];

  always_comb begin
    // NOTE: default assignment first so no path through this block can leave
    // up_ctr_nxt unassigned and infer a latch.
    up_ctr_nxt = up_ctr_cur;
    if (upd_is_jump) begin
      up_ctr_nxt = CTR_STRONG;
    end else if (upd_taken) begin
      if (up_ctr_cur != 2'b11) up_ctr_nxt = up_ctr_cur + 2'b01;
    end else begin
      if (up_ctr_cur != 2'b00) up_ctr_nxt = up_ctr_cur - 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Table write port
  // ---------------------------------------------------------------------------
  // NOTE: the table is built from flops (not RAM) because reset must clear
  // every entry at once; a RAM macro could not honour an asynchronous clear.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WEAK_NT;
        tgt_q[i]   <= '0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
        if (upd_taken) tgt_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Allocate, evicting whatever aliased into this slot.
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target;
        ctr_q[up_idx]   <= upd_is_jump ? CTR_STRONG : CTR_WEAK_T;
      end
      // Not-taken miss: nothing worth remembering, table left alone.
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (if_valid && (stat_lookups != 32'hFFFF_FFFF))
        stat_lookups <= stat_lookups + 32'd1;
      if (upd_valid && upd_mispred && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, 2..256; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter MODE, default 1; 0 = static not-taken, 1 = bimodal 2-bit.
REQ-004 SHALL have port cpu_clk  in  1  clock; reset cpu_rst, asynchronous, active-high; clock cpu_clk.
REQ-005 SHALL have port cpu_rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port if_valid  in  1  fetch stage presents a valid PC this cycle.
REQ-007 SHALL have port if_pc  in  PC_W  fetch PC.
REQ-008 SHALL have port pred_hit  out  1  valid entry with matching tag.
REQ-009 SHALL have port pred_taken  out  1  predict taken.
REQ-010 SHALL have port pred_target  out  PC_W  predicted target; 0 on miss.
REQ-011 SHALL have port upd_valid  in  1  resolved control-flow instruction.
REQ-012 SHALL have port upd_pc  in  PC_W  PC of the resolved instruction.
REQ-013 SHALL have port upd_taken  in  1  actual outcome.
REQ-014 SHALL have port upd_is_jump  in  1  unconditional jump (jal/jalr).
REQ-015 SHALL have port upd_target  in  PC_W  actual target.
REQ-016 SHALL have port upd_mispred  in  1  the pipeline flushed for this instruction.
REQ-017 SHALL have port stat_lookups  out  32  count of if_valid cycles.
REQ-018 SHALL have port stat_mispred  out  32  count of upd_valid & upd_mispred cycles.

Function
REQ-019 SHALL index the table by pc[IDX_W+1:2] and tag it with pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-020 SHALL hold per entry: valid, tag, 2-bit counter, target (PC_W).
REQ-021 SHALL compute lookup combinationally in the same cycle: pred_hit = valid & tag match.
REQ-022 SHALL drive pred_taken = pred_hit & counter[1] when MODE=1, and constant 0 when MODE=0.
REQ-023 SHALL update the table only at a posedge with upd_valid=1; single write port.
REQ-024 SHALL treat an update whose tag hits as follows: counter +1 saturating at 11 if taken, −1 saturating at 00 if not taken; target overwritten only if taken.
REQ-025 SHALL treat an update whose tag misses with upd_taken=1 by allocating (replacing any occupant): valid=1, new tag, target=upd_target, counter=10.
REQ-026 SHALL leave the table unchanged on a tag miss with upd_taken=0.
REQ-027 SHALL force the counter to 11 on any update with upd_is_jump=1, whether hit or miss.
REQ-028 SHALL, when lookup and update hit the same index in one cycle, return pre-update contents (no bypass); new contents are visible next cycle.
REQ-029 SHALL keep table updates and statistics active in MODE=0; only pred_taken is suppressed.
REQ-030 SHALL make stat_lookups and stat_mispred count up by 1 per qualifying cycle and saturate at 0xFFFF_FFFF.

Reset
REQ-031 SHALL, on cpu_rst assertion, immediately clear all valid bits, set all counters to 01, zero all targets, tags and both statistics counters, regardless of in-progress updates.
REQ-032 SHALL hold pred_hit=0, pred_taken=0 and pred_target=0 while in reset, and ignore upd_valid during reset.

Verification
REQ-033 SHALL verify reset state: after reset, if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x0, stats=0.
REQ-034 SHALL verify allocation: update pc=0x40, taken=1, target=0x100 -> next cycle lookup 0x40 gives hit=1, taken=1, target=0x100.
REQ-035 SHALL verify counter saturation: from 10, two not-taken updates -> 00, taken=0, hit=1; four taken updates -> 01,10,11,11.
REQ-036 SHALL verify aliasing (ENTRIES=16): with 0x40 allocated, lookup 0x80 (same index 0) -> hit=0; taken update of 0x80 target 0x200 -> lookup 0x40 misses, 0x80 hits with target 0x200.
REQ-037 SHALL verify same-cycle collision: lookup and not-taken update of 0x40 at counter 10 in one cycle -> taken=1 that cycle, taken=0 the next; jal update at 00 -> 11.
REQ-038 SHALL verify reset mid-operation and stats: after 5 if_valid cycles and 2 mispredicts, stats read 5/2; asserting cpu_rst mid-update clears table and stats the same cycle.
